// File: rtl/voting_pkg.sv
// Shared voting types: candidate count and the ballot FSM encoding used by
// the capture stage, vote logger and result display.
package voting_pkg;

  localparam int NUM_CANDIDATES = 4;

  typedef enum logic [1:0] {
    LOCKED  = 2'd0,
    ARMED   = 2'd1,
    RELEASE = 2'd2
  } vote_state_e;

  function automatic logic [2:0] count_ones(input logic [NUM_CANDIDATES-1:0] v);
    logic [2:0] n;
    n = '0;
    for (int i = 0; i < NUM_CANDIDATES; i++) begin
      n = n + {2'b00, v[i]};
    end
    return n;
  endfunction

endpackage

// File: rtl/button_debounce.sv
// Synchronise a raw asynchronous key, debounce it over DEBOUNCE_CYCLES stable
// cycles and emit a registered one-cycle pulse on each debounced rising edge.
module button_debounce #(
  parameter int DEBOUNCE_CYCLES = 16
) (
  input  logic clock,
  input  logic reset,
  input  logic raw_in,
  output logic level,
  output logic press
);

  localparam int CW = (DEBOUNCE_CYCLES > 2) ? $clog2(DEBOUNCE_CYCLES) : 1;

  logic          sync1_q, sync2_q;
  logic          level_q, level_d;
  logic          level_prev_q;
  logic          press_q;
  logic [CW-1:0] cnt_q, cnt_d;

  // Counter only runs while the synchronised input disagrees with the level.
  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (sync2_q != level_q) begin
      if (cnt_q == CW'(DEBOUNCE_CYCLES - 1)) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q      <= 1'b0;
      sync2_q      <= 1'b0;
      cnt_q        <= '0;
      level_q      <= 1'b0;
      level_prev_q <= 1'b0;
      press_q      <= 1'b0;
    end else begin
      sync1_q      <= raw_in;
      sync2_q      <= sync1_q;
      cnt_q        <= cnt_d;
      level_q      <= level_d;
      level_prev_q <= level_q;
      press_q      <= level_q & ~level_prev_q;
    end
  end

  assign level = level_q;
  assign press = press_q;

endmodule

// File: rtl/vote_capture.sv
// Voting front end: debounced buttons and officer key drive a one-vote-per-ballot
// FSM; every output is registered and squelched as soon as mode drops.
module vote_capture
  import voting_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int ARM_TIMEOUT     = 1024
) (
  input  logic clock,
  input  logic reset,
  input  logic mode,
  input  logic ballot_enable,
  input  logic button1,
  input  logic button2,
  input  logic button3,
  input  logic button4,
  output logic candidate1_vote_valid,
  output logic candidate2_vote_valid,
  output logic candidate3_vote_valid,
  output logic candidate4_vote_valid,
  output logic ballot_armed,
  output logic vote_reject,
  output logic arm_timeout
);

  localparam int TW = (ARM_TIMEOUT > 2) ? $clog2(ARM_TIMEOUT) : 1;

  logic [NUM_CANDIDATES-1:0] raw_btn, btn_level, btn_press;
  logic                      en_level, en_press;

  vote_state_e               state_q, state_d;
  logic [TW-1:0]             timer_q, timer_d;
  logic [NUM_CANDIDATES-1:0] vote_pend_q, vote_pend_d;
  logic                      reject_pend_q, reject_pend_d;
  logic                      timeout_pend_q, timeout_pend_d;
  logic [NUM_CANDIDATES-1:0] vote_q;
  logic                      armed_q, reject_q, timeout_q;
  logic                      accept;

  assign raw_btn = {button4, button3, button2, button1};

  for (genvar g = 0; g < NUM_CANDIDATES; g++) begin : g_btn
    button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clock  (clock),
      .reset  (reset),
      .raw_in (raw_btn[g]),
      .level  (btn_level[g]),
      .press  (btn_press[g])
    );
  end

  button_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_enable (
    .clock  (clock),
    .reset  (reset),
    .raw_in (ballot_enable),
    .level  (en_level),
    .press  (en_press)
  );

  // A lone press with every other button released; anything else is ambiguous.
  assign accept = (count_ones(btn_press) == 3'd1) && ((btn_level & ~btn_press) == '0);

  always_comb begin
    state_d        = state_q;
    timer_d        = timer_q;
    vote_pend_d    = '0;
    reject_pend_d  = 1'b0;
    timeout_pend_d = 1'b0;
    case (state_q)
      LOCKED: begin
        if (en_press && en_level) begin
          state_d = ARMED;
          timer_d = '0;
        end
      end
      ARMED: begin
        timer_d = timer_q + 1'b1;
        if (accept) begin
          vote_pend_d = btn_press;
          state_d     = RELEASE;
        end else begin
          reject_pend_d = (btn_press != '0);
          if (timer_q == TW'(ARM_TIMEOUT - 1)) begin
            timeout_pend_d = 1'b1;
            state_d        = LOCKED;
          end
        end
      end
      RELEASE: begin
        if (btn_level == '0) begin
          state_d = LOCKED;
        end
      end
      default: state_d = LOCKED;
    endcase
    if (!mode) begin
      state_d        = LOCKED;
      vote_pend_d    = '0;
      reject_pend_d  = 1'b0;
      timeout_pend_d = 1'b0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q        <= LOCKED;
      timer_q        <= '0;
      vote_pend_q    <= '0;
      reject_pend_q  <= 1'b0;
      timeout_pend_q <= 1'b0;
      vote_q         <= '0;
      armed_q        <= 1'b0;
      reject_q       <= 1'b0;
      timeout_q      <= 1'b0;
    end else begin
      state_q        <= state_d;
      timer_q        <= timer_d;
      vote_pend_q    <= vote_pend_d;
      reject_pend_q  <= reject_pend_d;
      timeout_pend_q <= timeout_pend_d;
      // Pending pulses die here if mode dropped in the cycle between.
      vote_q         <= mode ? vote_pend_q : '0;
      armed_q        <= mode && (state_q == ARMED);
      reject_q       <= mode && reject_pend_q;
      timeout_q      <= mode && timeout_pend_q;
    end
  end

  assign candidate1_vote_valid = vote_q[0];
  assign candidate2_vote_valid = vote_q[1];
  assign candidate3_vote_valid = vote_q[2];
  assign candidate4_vote_valid = vote_q[3];
  assign ballot_armed          = armed_q;
  assign vote_reject           = reject_q;
  assign arm_timeout           = timeout_q;

endmodule

// File: tb/tb_vote_capture.sv
// Bench for vote_capture: directed scenarios with literal timing expectations
// plus a randomized run compared every cycle against a behavioural model.
module tb_vote_capture;

  localparam int DC = 4;
  localparam int AT = 32;
  localparam int S_LOCKED = 0, S_ARMED = 1, S_REL = 2;

  logic clock = 1'b0;
  logic reset, mode, ballot_enable, button1, button2, button3, button4;
  logic candidate1_vote_valid, candidate2_vote_valid, candidate3_vote_valid, candidate4_vote_valid;
  logic ballot_armed, vote_reject, arm_timeout;

  always #5 clock = ~clock;

  vote_capture #(.DEBOUNCE_CYCLES(DC), .ARM_TIMEOUT(AT)) dut (
    .clock                 (clock),
    .reset                 (reset),
    .mode                  (mode),
    .ballot_enable         (ballot_enable),
    .button1               (button1),
    .button2               (button2),
    .button3               (button3),
    .button4               (button4),
    .candidate1_vote_valid (candidate1_vote_valid),
    .candidate2_vote_valid (candidate2_vote_valid),
    .candidate3_vote_valid (candidate3_vote_valid),
    .candidate4_vote_valid (candidate4_vote_valid),
    .ballot_armed          (ballot_armed),
    .vote_reject           (vote_reject),
    .arm_timeout           (arm_timeout)
  );

  int checks = 0, passes = 0, cyc = 0;
  bit chk_en = 0;

  // ---------------- behavioural model ----------------
  bit       hist [5][DC+2];   // raw samples, index 0 = newest
  bit       lvl [5], lvl_prev [5], prs [5];
  int       st = S_LOCKED, arm_cyc = 0;
  bit [3:0] vpend = '0, e_vote = '0;
  bit       rpend = 0, tpend = 0, e_armed = 0, e_rej = 0, e_to = 0;

  always @(posedge clock) begin
    bit raw [5];
    bit flip;
    bit [3:0] pb, lb;
    cyc++;
    raw[0] = button1; raw[1] = button2; raw[2] = button3; raw[3] = button4; raw[4] = ballot_enable;
    if (reset) begin
      for (int i = 0; i < 5; i++) begin
        for (int j = 0; j < DC + 2; j++) hist[i][j] = 0;
        lvl[i] = 0; lvl_prev[i] = 0; prs[i] = 0;
      end
      st = S_LOCKED; vpend = 0; rpend = 0; tpend = 0;
      e_vote = 0; e_armed = 0; e_rej = 0; e_to = 0;
    end else begin
      e_vote  = mode ? vpend : 4'b0;
      e_rej   = rpend && mode;
      e_to    = tpend && mode;
      e_armed = (st == S_ARMED) && mode;
      vpend = 0; rpend = 0; tpend = 0;
      pb = {prs[3], prs[2], prs[1], prs[0]};
      lb = {lvl[3], lvl[2], lvl[1], lvl[0]};
      if (!mode) st = S_LOCKED;
      else if (st == S_LOCKED) begin
        if (prs[4]) begin st = S_ARMED; arm_cyc = cyc; end
      end else if (st == S_ARMED) begin
        if ($countones(pb) == 1 && (lb & ~pb) == 0) begin
          vpend = pb; st = S_REL;
        end else begin
          rpend = (pb != 0);
          if (cyc - arm_cyc == AT) begin tpend = 1; st = S_LOCKED; end
        end
      end else if (lb == 0) st = S_LOCKED;
      for (int i = 0; i < 5; i++) begin
        for (int j = DC + 1; j > 0; j--) hist[i][j] = hist[i][j-1];
        hist[i][0] = raw[i];
        // level flips once the last DC synchronised samples all disagree with it
        flip = 1;
        for (int j = 2; j <= DC + 1; j++) if (hist[i][j] == lvl[i]) flip = 0;
        prs[i]      = lvl[i] & ~lvl_prev[i];
        lvl_prev[i] = lvl[i];
        if (flip) lvl[i] = ~lvl[i];
      end
    end
  end

  // ---------------- compare + event counters ----------------
  int       cnt_vote [4];
  int       last_vote_cyc [4];
  int       cnt_rej = 0, cnt_to = 0, last_to_cyc = 0;
  bit       armed_at_vote = 0;

  always @(posedge clock) begin
    logic [6:0] got, exp;
    logic [3:0] v;
    #2;
    v = {candidate4_vote_valid, candidate3_vote_valid, candidate2_vote_valid, candidate1_vote_valid};
    if (chk_en) begin
      got = {v, ballot_armed, vote_reject, arm_timeout};
      exp = {e_vote, e_armed, e_rej, e_to};
      checks++;
      if (got === exp) passes++;
      else $display("FAIL model_cmp cyc=%0d got=%b expected=%b", cyc, got, exp);
      checks++;
      if ($countones(v) <= 1) passes++;
      else $display("FAIL onehot cyc=%0d got=%b expected at most one bit", cyc, v);
    end
    for (int i = 0; i < 4; i++) if (v[i] === 1'b1) begin
      cnt_vote[i]++; last_vote_cyc[i] = cyc; armed_at_vote = ballot_armed;
    end
    if (vote_reject === 1'b1) cnt_rej++;
    if (arm_timeout === 1'b1) begin cnt_to++; last_to_cyc = cyc; end
  end

  // ---------------- helpers ----------------
  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic clr_counts();
    for (int i = 0; i < 4; i++) cnt_vote[i] = 0;
    cnt_rej = 0; cnt_to = 0;
  endtask

  function automatic int total_votes();
    return cnt_vote[0] + cnt_vote[1] + cnt_vote[2] + cnt_vote[3];
  endfunction

  task automatic set_btn(input logic [3:0] b);
    {button4, button3, button2, button1} = b;
  endtask

  // Press the officer key until the ballot shows armed; rise = edge of arming.
  task automatic arm(output int rise);
    rise = -1;
    ballot_enable = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clock);
      if (ballot_armed === 1'b1) begin rise = cyc; break; end
    end
    ballot_enable = 0;
    chk("arm_reached", (rise >= 0) ? 1 : 0, 1);
  endtask

  task automatic settle();
    set_btn(4'b0); ballot_enable = 0; mode = 1;
    tick(DC + 8);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int r, k;
    reset = 1; mode = 0; ballot_enable = 0; set_btn(4'b0);
    for (int i = 0; i < 4; i++) begin cnt_vote[i] = 0; last_vote_cyc[i] = 0; end
    tick(1);
    chk_en = 1;
    tick(2);
    chk("reset_outputs", {candidate1_vote_valid, candidate2_vote_valid, candidate3_vote_valid,
                          candidate4_vote_valid, ballot_armed, vote_reject, arm_timeout}, 0);
    reset = 0; mode = 1;
    tick(3);

    // 1. basic vote, latency pinned to DC+4 edges after first sample
    arm(r);
    clr_counts();
    set_btn(4'b0100); k = cyc + 1;
    tick(20);
    chk("t1_c3_pulses", cnt_vote[2], 1);
    chk("t1_other_pulses", total_votes() - cnt_vote[2], 0);
    chk("t1_latency", last_vote_cyc[2] - k, 8);
    chk("t1_armed_with_pulse", armed_at_vote, 0);
    settle();

    // 2a. bouncing button while armed, then let it expire
    arm(r);
    clr_counts();
    for (int i = 0; i < 10; i++) begin button2 = ~button2; tick(2); end
    button2 = 0;
    tick(AT);
    chk("t2a_votes", total_votes(), 0);
    chk("t2a_rejects", cnt_rej, 0);
    // 2b. press while locked
    clr_counts();
    button1 = 1; tick(14); button1 = 0; tick(DC + 6);
    chk("t2b_votes", total_votes(), 0);

    // 3. held button must not carry over to the next ballot
    arm(r);
    button1 = 1; tick(12);
    chk("t3_first_vote", cnt_vote[0], 1);
    clr_counts();
    ballot_enable = 1; tick(12); ballot_enable = 0; tick(2);
    chk("t3_rearm_ignored", ballot_armed, 0);
    button1 = 0; tick(DC + 6);
    arm(r);
    button4 = 1; tick(12); button4 = 0;
    chk("t3_c4_vote", cnt_vote[3], 1);
    chk("t3_no_c1_again", cnt_vote[0], 0);
    settle();

    // 4. ambiguous press rejected, ballot stays open
    arm(r);
    clr_counts();
    set_btn(4'b0011); tick(12);
    chk("t4_reject", cnt_rej, 1);
    chk("t4_no_vote", total_votes(), 0);
    chk("t4_still_armed", ballot_armed, 1);
    set_btn(4'b0000); tick(DC + 4);
    button2 = 1; tick(12);
    chk("t4_c2_vote", cnt_vote[1], 1);
    settle();

    // 5a. timeout exactly AT cycles after arming
    arm(r);
    clr_counts();
    for (int i = 0; i < AT + 10 && cnt_to == 0; i++) tick(1);
    chk("t5a_timeout_count", cnt_to, 1);
    chk("t5a_timeout_delay", last_to_cyc - r, 32);
    chk("t5a_disarmed", ballot_armed, 0);
    settle();
    // 5b. mode drop closes the ballot
    arm(r);
    clr_counts();
    mode = 0; tick(1);
    chk("t5b_disarmed", ballot_armed, 0);
    button2 = 1; tick(14);
    mode = 1; tick(4);
    chk("t5b_no_vote", total_votes(), 0);
    settle();

    // 6. reset mid-ballot with debounce in flight
    arm(r);
    clr_counts();
    button1 = 1; tick(2);
    reset = 1; tick(1);
    chk("t6_outputs_zero", {candidate1_vote_valid, candidate2_vote_valid, candidate3_vote_valid,
                            candidate4_vote_valid, ballot_armed, vote_reject, arm_timeout}, 0);
    reset = 0; tick(16);
    chk("t6_no_vote", total_votes(), 0);
    settle();

    // randomized run
    for (int n = 0; n < 4000; n++) begin
      for (int b = 0; b < 4; b++)
        if ($urandom_range(15) == 0) set_btn({button4, button3, button2, button1} ^ (4'b1 << b));
      if ($urandom_range(11) == 0) ballot_enable = ~ballot_enable;
      if (mode && $urandom_range(299) == 0) mode = 0;
      else if (!mode && $urandom_range(9) == 0) mode = 1;
      reset = ($urandom_range(799) == 0);
      tick(1);
    end
    reset = 0;
    tick(2);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
